// File: rtl/usb_ep_dispatcher.sv
// USB endpoint dispatcher: decodes tokens for this device, routes DATA
// payload (CRC16 stripped) to an endpoint, tracks data toggles and
// requests the ACK/NAK/STALL handshake.
// Ports: clk48/rst; device_addr; rx_* byte stream from the SIE;
//   ep_stall/ep_out_ready/ep_toggle_clr per endpoint; hs_ack from SIE TX;
//   out_* payload stream with commit/discard; in_token/in_ep;
//   hs_req/hs_pid handshake request; ep_toggle expected DATA PID.
module usb_ep_dispatcher #(
   parameter int ENDPOINTS      = 4,
   parameter int MAX_PACKET     = 64,
   parameter int TIMEOUT_CYCLES = 72
) (
   input  logic                 clk48,
   input  logic                 rst,
   input  logic [6:0]           device_addr,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic                 rx_last,
   input  logic                 rx_crc_ok,
   input  logic [ENDPOINTS-1:0] ep_stall,
   input  logic [ENDPOINTS-1:0] ep_out_ready,
   input  logic [ENDPOINTS-1:0] ep_toggle_clr,
   input  logic                 hs_ack,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic [3:0]           out_ep,
   output logic                 out_setup,
   output logic                 out_commit,
   output logic                 out_discard,
   output logic                 in_token,
   output logic [3:0]           in_ep,
   output logic                 hs_req,
   output logic [3:0]           hs_pid,
   output logic [ENDPOINTS-1:0] ep_toggle
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW = $clog2(MAX_PACKET + 1);

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TOKEN,
      S_WAIT,
      S_DATA,
      S_HS,
      S_IGNORE
   } state_t;

   state_t          state;
   logic [3:0]      tok_pid;
   logic            tok_second;
   logic [7:0]      b1;
   logic [3:0]      cur_ep;
   logic            cur_setup;
   logic [TW-1:0]   timer;
   logic            suppress;
   logic            f_stall;
   logic            f_nrdy;
   logic            f_mism;
   logic [7:0]      d0;
   logic [7:0]      d1;
   logic [1:0]      cnt;
   logic [PW-1:0]   pay_cnt;
   logic            overflow;
   logic            any_fwd;

   logic                 pid_ok;
   logic [3:0]           pid;
   logic                 is_token;
   logic [3:0]           tok_ep;
   logic                 tok_hit;
   logic [ENDPOINTS-1:0] ep_oh;
   logic                 sel_stall;
   logic                 sel_ready;
   logic                 sel_tog;
   logic                 pid_tog;
   logic                 fwd_slot;
   logic                 ovf_now;
   logic                 do_fwd;
   logic                 fwd_any_now;
   logic                 short_pkt;

   assign pid      = rx_data[3:0];
   assign pid_ok   = (rx_data[7:4] == ~rx_data[3:0]);
   assign is_token = (pid == PID_OUT) || (pid == PID_IN) ||
                     (pid == PID_SETUP);
   assign tok_ep   = {rx_data[2:0], b1[7]};
   assign tok_hit  = rx_crc_ok && (b1[6:0] == device_addr) &&
                     ({1'b0, tok_ep} < 5'(ENDPOINTS));
   assign pid_tog  = rx_data[3];

   always_comb begin
      ep_oh = '0;
      for (int i = 0; i < ENDPOINTS; i++)
         ep_oh[i] = (cur_ep == 4'(i));
   end

   assign sel_stall = |(ep_stall & ep_oh);
   assign sel_ready = |(ep_out_ready & ep_oh);
   assign sel_tog   = |(ep_toggle & ep_oh);

   // Two bytes are already held when a new one arrives: the oldest is
   // payload, the newest two may be the CRC16.
   assign fwd_slot    = (cnt == 2'd2);
   assign ovf_now     = overflow |
                        (fwd_slot && (pay_cnt == PW'(MAX_PACKET)));
   assign do_fwd      = fwd_slot && !ovf_now && !suppress;
   assign fwd_any_now = any_fwd | do_fwd;
   assign short_pkt   = (cnt == 2'd0);

   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         tok_pid     <= '0;
         tok_second  <= 1'b0;
         b1          <= '0;
         cur_ep      <= '0;
         cur_setup   <= 1'b0;
         timer       <= '0;
         suppress    <= 1'b0;
         f_stall     <= 1'b0;
         f_nrdy      <= 1'b0;
         f_mism      <= 1'b0;
         d0          <= '0;
         d1          <= '0;
         cnt         <= '0;
         pay_cnt     <= '0;
         overflow    <= 1'b0;
         any_fwd     <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_ep      <= '0;
         out_setup   <= 1'b0;
         out_commit  <= 1'b0;
         out_discard <= 1'b0;
         in_token    <= 1'b0;
         in_ep       <= '0;
         hs_req      <= 1'b0;
         hs_pid      <= '0;
         ep_toggle   <= '0;
      end else begin
         out_valid   <= 1'b0;
         out_commit  <= 1'b0;
         out_discard <= 1'b0;
         in_token    <= 1'b0;
         ep_toggle   <= ep_toggle & ~ep_toggle_clr;

         case (state)
            S_IDLE: begin
               if (rx_valid && !rx_last) begin
                  tok_pid    <= pid;
                  tok_second <= 1'b0;
                  state      <= (pid_ok && is_token) ? S_TOKEN : S_IGNORE;
               end
            end

            S_TOKEN: begin
               if (rx_valid) begin
                  if (!tok_second) begin
                     b1         <= rx_data;
                     tok_second <= 1'b1;
                     if (rx_last)
                        state <= S_IDLE;
                  end else if (!rx_last) begin
                     state <= S_IGNORE;
                  end else if (!tok_hit) begin
                     state <= S_IDLE;
                  end else if (tok_pid == PID_IN) begin
                     in_token <= 1'b1;
                     in_ep    <= tok_ep;
                     state    <= S_IDLE;
                  end else begin
                     cur_ep    <= tok_ep;
                     cur_setup <= (tok_pid == PID_SETUP);
                     timer     <= '0;
                     state     <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (rx_valid) begin
                  if (!pid_ok ||
                      !((pid == PID_DATA0) || (pid == PID_DATA1)) ||
                      (cur_setup && pid == PID_DATA1)) begin
                     state <= rx_last ? S_IDLE : S_IGNORE;
                  end else if (rx_last) begin
                     // Bare DATA PID: nothing after it to keep.
                     out_discard <= 1'b1;
                     state       <= S_IDLE;
                  end else begin
                     f_stall   <= !cur_setup && sel_stall;
                     f_nrdy    <= !cur_setup && !sel_ready;
                     f_mism    <= !cur_setup && (pid_tog != sel_tog);
                     suppress  <= !cur_setup &&
                                  (sel_stall || !sel_ready ||
                                   (pid_tog != sel_tog));
                     cnt       <= '0;
                     pay_cnt   <= '0;
                     overflow  <= 1'b0;
                     any_fwd   <= 1'b0;
                     out_ep    <= cur_ep;
                     out_setup <= cur_setup;
                     state     <= S_DATA;
                  end
               end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  state <= S_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            S_DATA: begin
               if (rx_valid) begin
                  d0 <= d1;
                  d1 <= rx_data;
                  if (!fwd_slot)
                     cnt <= cnt + 1'b1;
                  if (fwd_slot) begin
                     if (pay_cnt == PW'(MAX_PACKET))
                        overflow <= 1'b1;
                     else
                        pay_cnt <= pay_cnt + 1'b1;
                  end
                  if (do_fwd) begin
                     out_valid <= 1'b1;
                     out_data  <= d0;
                     any_fwd   <= 1'b1;
                  end
                  if (rx_last) begin
                     state <= S_HS;
                     if (!rx_crc_ok || ovf_now || short_pkt) begin
                        out_discard <= 1'b1;
                        state       <= S_IDLE;
                     end else if (cur_setup) begin
                        out_commit <= 1'b1;
                        hs_req     <= 1'b1;
                        hs_pid     <= PID_ACK;
                        ep_toggle  <= (ep_toggle | ep_oh) & ~ep_toggle_clr;
                     end else if (f_stall) begin
                        out_discard <= fwd_any_now;
                        hs_req      <= 1'b1;
                        hs_pid      <= PID_STALL;
                     end else if (f_nrdy) begin
                        out_discard <= fwd_any_now;
                        hs_req      <= 1'b1;
                        hs_pid      <= PID_NAK;
                     end else if (f_mism) begin
                        out_discard <= fwd_any_now;
                        hs_req      <= 1'b1;
                        hs_pid      <= PID_ACK;
                     end else begin
                        out_commit <= 1'b1;
                        hs_req     <= 1'b1;
                        hs_pid     <= PID_ACK;
                        ep_toggle  <= (ep_toggle ^ ep_oh) & ~ep_toggle_clr;
                     end
                  end
               end
            end

            S_HS: begin
               if (hs_ack) begin
                  hs_req <= 1'b0;
                  state  <= S_IDLE;
               end
            end

            S_IGNORE: begin
               if (rx_valid && rx_last)
                  state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
